// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider (DIV/DIVU).
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bus between control unit and divider.
// div_unsigned exists only when DIV_UNSIGNED_EN is defined.
interface div_if #(
    parameter int DATA_WIDTH = div_pkg::DIV_WIDTH
);
    logic                  div_start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
`ifdef DIV_UNSIGNED_EN
    logic                  div_unsigned;
`endif
    logic [DATA_WIDTH-1:0] hi_div;
    logic [DATA_WIDTH-1:0] lo_div;
    logic                  div_busy;
    logic                  div_done;
    logic                  div_zero;

    modport master (
`ifdef DIV_UNSIGNED_EN
        output div_unsigned,
`endif
        output div_start,
        output dividend,
        output divisor,
        input  hi_div,
        input  lo_div,
        input  div_busy,
        input  div_done,
        input  div_zero
    );

    modport slave (
`ifdef DIV_UNSIGNED_EN
        input  div_unsigned,
`endif
        input  div_start,
        input  dividend,
        input  divisor,
        output hi_div,
        output lo_div,
        output div_busy,
        output div_done,
        output div_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           take;

    // The shifted remainder can exceed WIDTH bits, so the compare is one bit wider.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign take     = (shifted >= {1'b0, dsr});
    assign rem_next = take ? WIDTH'(shifted - {1'b0, dsr}) : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], take};

endmodule

// File: rtl/div.sv
// Multi-cycle signed 32-bit divider: quotient on lo_div, remainder on hi_div.
// Define DIV_UNSIGNED_EN to add the div_unsigned input (DIVU support).
module div
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_WIDTH
) (
    input  logic clock,
    input  logic reset,
    div_if.slave bus
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DATA_WIDTH - 1);

    div_state_t            state;
    div_state_t            state_next;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quo_step;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dsr_mag;
    logic [DIV_CNT_W-1:0]  count;
    logic                  quo_neg;
    logic                  rem_neg;
    logic                  zero_q;
    logic                  busy;
    logic                  done;
    logic                  uns;
    logic                  dvd_neg;
    logic                  dsr_neg;
    logic                  start_ok;
    logic                  divisor_zero;

`ifdef DIV_UNSIGNED_EN
    assign uns = bus.div_unsigned;
`else
    assign uns = 1'b0;
`endif

    // Unsigned mode takes raw operands as magnitudes; |0x80000000| stays 0x80000000.
    assign dvd_neg      = ~uns & bus.dividend[DATA_WIDTH-1];
    assign dsr_neg      = ~uns & bus.divisor[DATA_WIDTH-1];
    assign dvd_mag      = dvd_neg ? -bus.dividend : bus.dividend;
    assign dsr_mag      = dsr_neg ? -bus.divisor : bus.divisor;
    assign start_ok     = (state == IDLE) && bus.div_start;
    assign divisor_zero = (bus.divisor == '0);

    div_step #(.WIDTH(DATA_WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dsr      (dsr),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.div_start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are only written on FIX or a divide-by-zero start, so they hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            dsr     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        zero_q <= divisor_zero;
                        if (divisor_zero) begin
                            hi_q <= bus.dividend;
                            lo_q <= DATA_WIDTH'(DIV_ZERO_QUOT);
                        end else begin
                            rem     <= '0;
                            quo     <= dvd_mag;
                            dsr     <= dsr_mag;
                            quo_neg <= dvd_neg ^ dsr_neg;
                            rem_neg <= dvd_neg;
                            count   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    lo_q <= quo_neg ? -quo : quo;
                    hi_q <= rem_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_div   = hi_q;
    assign bus.lo_div   = lo_q;
    assign bus.div_busy = busy;
    assign bus.div_done = done;
    assign bus.div_zero = zero_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: scoreboard of expected results checked on div_done.
module tb_div;
    import div_pkg::*;

    logic clock = 1'b0;
    logic reset;

    div_if bus ();

    div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        int          latency;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference uses the language's own truncating division, not a restoring loop.
    function automatic exp_t model(input string name, input logic [31:0] a, input logic [31:0] b,
                                   input logic uns);
        exp_t              e;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa     = a;
        sb     = b;
        e.name = name;
        if (b == 32'd0) begin
            e.lo      = 32'hFFFF_FFFF;
            e.hi      = a;
            e.zero    = 1'b1;
            e.latency = 1;
        end else begin
            e.zero    = 1'b0;
            e.latency = 34;
            if (uns) begin
                e.lo = a / b;
                e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'd0;
            end else begin
                e.lo = 32'(sa / sb);
                e.hi = 32'(sa % sb);
            end
        end
        return e;
    endfunction

    // Called in an IDLE cycle, just after a clock edge; start is sampled at the next edge.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic uns);
        exp_q.push_back(model(name, a, b, uns));
        bus.div_start = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = uns;
`endif
    endtask

    task automatic waitResult(input int glitch_at, input logic [31:0] ga, input logic [31:0] gb);
        int          edges       = 0;
        int          busy_cycles = 0;
        bit          seen        = 0;
        exp_t        e;
        logic [31:0] a_hold;
        logic [31:0] b_hold;
        a_hold = bus.dividend;
        b_hold = bus.divisor;
        while (!seen && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 1) begin
                bus.div_start = 1'b0;
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
            end
            if (glitch_at > 1 && edges == glitch_at) begin
                bus.div_start = 1'b1;
                bus.dividend  = ga;
                bus.divisor   = gb;
            end else if (glitch_at > 1 && edges == glitch_at + 1) begin
                bus.div_start = 1'b0;
                bus.dividend  = a_hold;
                bus.divisor   = b_hold;
            end
            if (bus.div_busy) busy_cycles++;
            if (bus.div_done) seen = 1;
        end
        checkOutput("scoreboard depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s done seen", e.name), 32'(seen), 1);
            checkOutput($sformatf("%s latency", e.name), edges, e.latency);
            checkOutput($sformatf("%s busy cycles", e.name), busy_cycles, (e.latency == 1) ? 0 : 33);
            checkOutput($sformatf("%s lo", e.name), bus.lo_div, e.lo);
            checkOutput($sformatf("%s hi", e.name), bus.hi_div, e.hi);
            checkOutput($sformatf("%s zero", e.name), bus.div_zero, e.zero);
            @(posedge clock);
            #1;
            checkOutput($sformatf("%s done pulse", e.name), bus.div_done, 0);
            checkOutput($sformatf("%s lo held", e.name), bus.lo_div, e.lo);
            checkOutput($sformatf("%s zero held", e.name), bus.div_zero, e.zero);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        reset         = 1'b1;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset hi", bus.hi_div, 0);
        checkOutput("reset lo", bus.lo_div, 0);
        checkOutput("reset busy", bus.div_busy, 0);
        checkOutput("reset done", bus.div_done, 0);
        checkOutput("reset zero", bus.div_zero, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        applyStimulus("7/2", 32'd7, 32'd2, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("-7/2", -32'sd7, 32'd2, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("7/-2", 32'd7, -32'sd2, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("-8/-2", -32'sd8, -32'sd2, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("123/0", 32'd123, 32'd0, 1'b0);
        waitResult(0, 0, 0);

        applyStimulus("100/7 ignore restart", 32'd100, 32'd7, 1'b0);
        waitResult(10, 32'd9, 32'd3);
        applyStimulus("10/3 back-to-back", 32'd10, 32'd3, 1'b0);
        waitResult(0, 0, 0);

        applyStimulus("50/5 aborted", 32'd50, 32'd5, 1'b0);
        @(posedge clock);
        #1;
        bus.div_start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        checkOutput("busy before abort", bus.div_busy, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort hi", bus.hi_div, 0);
        checkOutput("abort lo", bus.lo_div, 0);
        checkOutput("abort busy", bus.div_busy, 0);
        checkOutput("abort done", bus.div_done, 0);
        checkOutput("abort zero", bus.div_zero, 0);
        reset = 1'b0;
        void'(exp_q.pop_front());
        done_cnt = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.div_done) done_cnt++;
        end
        checkOutput("no done after abort", done_cnt, 0);

        applyStimulus("1000/-33", 32'd1000, -32'sd33, 1'b0);
        waitResult(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            applyStimulus($sformatf("rand%0d", i), ra, rb, 1'b0);
            waitResult(0, 0, 0);
        end

`ifdef DIV_UNSIGNED_EN
        applyStimulus("divu ffffffff/2", 32'hFFFF_FFFF, 32'd2, 1'b1);
        waitResult(0, 0, 0);
        applyStimulus("div ffffffff/2", 32'hFFFF_FFFF, 32'd2, 1'b0);
        waitResult(0, 0, 0);
        applyStimulus("divu 80000005/0", 32'h8000_0005, 32'd0, 1'b1);
        waitResult(0, 0, 0);
        applyStimulus("divu 80000000/3", 32'h8000_0000, 32'd3, 1'b1);
        waitResult(0, 0, 0);
`endif

        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
